// File: rtl/barrel_shift_seq_if.sv
// Command and shifter-control bundle for the multi-pass shift sequencer.
// slave: the sequencer side. master: the front-end plus barrel shifter side.
interface barrel_shift_seq_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 5
);
  logic             start;
  logic [WIDTH-1:0] din;
  logic [AMT_W-1:0] amt;
  logic             lr;
  logic             al;
  logic [WIDTH-1:0] sh_din;
  logic [2:0]       sh_shamt;
  logic             sh_lr;
  logic             sh_al;
  logic [WIDTH-1:0] sh_dout;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  modport slave (
    input  start, din, amt, lr, al, sh_dout,
    output sh_din, sh_shamt, sh_lr, sh_al, busy, done, dout
  );

  modport master (
    output start, din, amt, lr, al, sh_dout,
    input  sh_din, sh_shamt, sh_lr, sh_al, busy, done, dout
  );
endinterface

// File: rtl/barrel_shift_seq.sv
// Breaks a 0..2^AMT_W-1 shift into passes of at most STEP_MAX through an
// external combinational barrel shifter, accumulating each pass result.
module barrel_shift_seq #(
  parameter int WIDTH    = 8,
  parameter int AMT_W    = 5,
  parameter int STEP_MAX = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  barrel_shift_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] STEP_L = AMT_W'(STEP_MAX);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_acc;
  logic [AMT_W-1:0] r_rem;
  logic             r_lr;
  logic             r_al;
  logic [WIDTH-1:0] r_dout;
  logic [AMT_W-1:0] w_step;
  logic             w_accept;

  assign w_step   = (r_rem > STEP_L) ? STEP_L : r_rem;
  assign w_accept = bus.start && (r_state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (r_rem == '0) w_next = DONE;
      DONE:    w_next = bus.start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.sh_shamt = 3'd0;
    case (r_state)
      RUN: begin
        bus.busy = 1'b1;
        if (r_rem != '0) bus.sh_shamt = w_step[2:0];
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, per-pass accumulate, and result capture on RUN exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_rem  <= '0;
      r_lr   <= 1'b0;
      r_al   <= 1'b0;
      r_dout <= '0;
    end else if (w_accept) begin
      r_acc <= bus.din;
      r_rem <= bus.amt;
      r_lr  <= bus.lr;
      r_al  <= bus.al;
    end else if (r_state == RUN) begin
      if (r_rem != '0) begin
        r_acc <= bus.sh_dout;
        r_rem <= r_rem - w_step;
      end else begin
        r_dout <= r_acc;
      end
    end
  end

  assign bus.sh_din = r_acc;
  assign bus.sh_lr  = r_lr;
  assign bus.sh_al  = r_al;
  assign bus.dout   = r_dout;

endmodule

// File: tb/tb_barrel_shift_seq.sv
// Scoreboard bench: commands push whole-distance expected results, a monitor
// checks per-pass distances, latency and final result on each done pulse.
module tb_barrel_shift_seq;

  localparam int WIDTH = 8;
  localparam int AMT_W = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  barrel_shift_seq_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) bus ();

  barrel_shift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W), .STEP_MAX(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Lab barrel shifter: at most 7 positions per pass, al ignored on left shifts.
  always_comb begin
    if (bus.sh_lr)      bus.sh_dout = bus.sh_din << bus.sh_shamt;
    else if (bus.sh_al) bus.sh_dout = $signed(bus.sh_din) >>> bus.sh_shamt;
    else                bus.sh_dout = bus.sh_din >> bus.sh_shamt;
  end

  typedef struct {
    logic [7:0] din;
    int         amt;
    logic [7:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] ref_shift(logic [7:0] d, int a, logic l, logic ar);
    int v;
    if (l) begin
      v = (a >= 8) ? 0 : (int'(d) << a);
    end else if (ar) begin
      v = d[7] ? (int'(d) - 256) : int'(d);
      v = v >>> a;
    end else begin
      v = int'(d) >> a;
    end
    return v[7:0];
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor
  int         m_cyc, m_passes, m_sum, m_rem;
  logic [7:0] m_prev_dout;
  exp_t       m_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_cyc = 0; m_passes = 0; m_sum = 0; m_prev_dout = 8'h00;
    end else begin
      if (bus.busy) begin
        m_cyc++;
        if (bus.sh_shamt != 3'd0) begin
          m_passes++;
          if (sb.size() == 0) begin
            chk("shamt_without_cmd", int'(bus.sh_shamt), 0);
          end else begin
            m_rem = sb[0].amt - m_sum;
            chk("sh_shamt", int'(bus.sh_shamt), (m_rem > 7) ? 7 : m_rem);
          end
          m_sum += int'(bus.sh_shamt);
        end
      end
      if (bus.done) begin
        chk("done_with_busy", int'(bus.busy), 0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          m_e = sb.pop_front();
          chk("dout", int'(bus.dout), int'(m_e.exp));
          chk("pass_total", m_sum, m_e.amt);
          chk("pass_count", m_passes, (m_e.amt + 6) / 7);
          chk("busy_cycles", m_cyc, (m_e.amt + 6) / 7 + 1);
        end
        m_cyc = 0; m_passes = 0; m_sum = 0;
      end else if (bus.dout !== m_prev_dout) begin
        chk("dout_hold", int'(bus.dout), int'(m_prev_dout));
      end
      m_prev_dout = bus.dout;
    end
  end

  task automatic issue(input logic [7:0] d, input int a, input logic l, input logic ar);
    exp_t e;
    bus.din   = d;
    bus.amt   = a[4:0];
    bus.lr    = l;
    bus.al    = ar;
    bus.start = 1'b1;
    if (!bus.busy) begin
      e.din = d; e.amt = a; e.exp = ref_shift(d, a, l, ar);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.din = '0; bus.amt = '0; bus.lr = 1'b0; bus.al = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_dout", int'(bus.dout), 0);
    chk("rst_shamt", int'(bus.sh_shamt), 0);
    chk("rst_sh_din", int'(bus.sh_din), 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(8'h81, 3, 1'b1, 1'b0);
    wait_done();
    @(posedge clk); #1;

    issue(8'h80, 10, 1'b0, 1'b1);
    wait_done();
    issue(8'hF0, 31, 1'b0, 1'b0);
    wait_done();
    @(posedge clk); #1;

    issue(8'h5A, 0, 1'b0, 1'b0);
    wait_done();
    @(posedge clk); #1;

    issue(8'h01, 14, 1'b1, 1'b0);
    @(posedge clk); #1;
    issue(8'hFF, 0, 1'b0, 1'b0);
    wait_done();
    issue(8'h3C, 2, 1'b0, 1'b0);
    chk("accept_in_done", int'(bus.busy), 1);
    wait_done();
    @(posedge clk); #1;

    issue(8'hAA, 20, 1'b0, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", int'(bus.busy), 0);
    chk("async_rst_done", int'(bus.done), 0);
    chk("async_rst_dout", int'(bus.dout), 0);
    chk("async_rst_shamt", int'(bus.sh_shamt), 0);
    sb.delete();
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(8'hC3, 5, 1'b1, 1'b0);
    wait_done();
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom_range(0, 255)), int'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done();
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
    end

    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
